// File: rtl/rpm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rpm_scheduler
// Purpose  : Measures the motor pole-change period from the asynchronous
//            `blips` square wave, rejects glitches, and schedules one RPM
//            division per measured period on a shared iterative divider
//            (req/ack). Publishes a saturated 10-bit RPM and a stall flag.
// Ports    : clk50M    - system clock (only clock)
//            rst_n     - asynchronous active-low reset
//            blips     - asynchronous pole-change square wave
//            div_req   - divide request (level, held until ack)
//            div_num   - dividend, constant CLK_HZ*60
//            div_den   - divisor, period*POLES*GEAR saturated to 32 bits
//            div_ack   - one-cycle divider completion pulse
//            div_quot  - quotient, valid with div_ack
//            rpm       - speed, saturated to 1023
//            rpm_valid - one-cycle pulse when rpm updates
//            stalled   - high while no valid period exists
// Revision : 1.0 - initial release
// ============================================================================
module rpm_scheduler #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned POLES          = 16,
    parameter int unsigned GEAR           = 5,
    parameter int unsigned MIN_PERIOD     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  logic        blips,
    output logic        div_req,
    output logic [31:0] div_num,
    output logic [31:0] div_den,
    input  logic        div_ack,
    input  logic [31:0] div_quot,
    output logic [9:0]  rpm,
    output logic        rpm_valid,
    output logic        stalled
);

    localparam logic [31:0] C_DIV_NUM = 32'(64'(CLK_HZ) * 64'd60);
    localparam logic [31:0] C_PG      = 32'(POLES * GEAR);
    localparam logic [31:0] C_MIN     = 32'(MIN_PERIOD);
    localparam logic [31:0] C_TMO     = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] C_SAT     = 32'hFFFF_FFFF;
    localparam logic [9:0]  C_RPM_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_MEAS = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    // Registered state
    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync3_q, sync3_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] slot_q, slot_d;
    logic [31:0] den_q, den_d;
    logic        req_q, req_d;
    logic [9:0]  rpm_q, rpm_d;
    logic        rpm_valid_q, rpm_valid_d;
    logic        stalled_q, stalled_d;

    // Combinational helpers
    logic        w_rise;
    logic [31:0] w_cand;
    logic        w_accept;
    logic        w_timeout;
    logic        w_use_slot;
    logic [31:0] w_mul_op;
    logic [63:0] w_prod;
    logic [31:0] w_den_sat;
    logic [9:0]  w_quot_sat;

    always_comb begin
        w_rise   = sync2_q & ~sync3_q;
        // Candidate period: edges N cycles apart measure N. Saturates with
        // the counter so a very long gap never wraps to a short period.
        w_cand   = (cnt_q == C_SAT) ? C_SAT : (cnt_q + 32'd1);
        w_accept = w_rise && ((state_q == ST_ARM) || (w_cand >= C_MIN));
        // An accepted edge in the same cycle always beats the timeout.
        w_timeout = (state_q != ST_ARM) && (w_cand >= C_TMO) && !w_accept;
        // The single multiplier serves either the live edge or the pending
        // slot; the slot is used only when it is being drained on an ack
        // with no newer edge arriving in that same cycle.
        w_use_slot = (state_q == ST_REQ) && div_ack && pend_q && !w_accept;
        w_mul_op   = w_use_slot ? slot_q : w_cand;
        w_prod     = 64'(w_mul_op) * 64'(C_PG);
        w_den_sat  = (w_prod[63:32] != 32'd0) ? C_SAT : w_prod[31:0];
        w_quot_sat = (div_quot > 32'(C_RPM_MAX)) ? C_RPM_MAX : div_quot[9:0];
    end

    always_comb begin
        sync1_d     = blips;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        cnt_d       = w_accept ? 32'd0 : w_cand;
        state_d     = state_q;
        pend_d      = pend_q;
        slot_d      = slot_q;
        den_d       = den_q;
        rpm_d       = rpm_q;
        rpm_valid_d = 1'b0;
        stalled_d   = stalled_q;

        case (state_q)
            ST_ARM: begin
                stalled_d = 1'b1;
                pend_d    = 1'b0;
                // First edge only starts the measurement window.
                if (w_accept) begin
                    state_d = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (w_accept) begin
                    den_d   = w_den_sat;
                    state_d = ST_REQ;
                end else if (w_timeout) begin
                    rpm_d     = 10'd0;
                    stalled_d = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = ST_ARM;
                end
            end
            ST_REQ: begin
                if (w_timeout) begin
                    rpm_d     = 10'd0;
                    stalled_d = 1'b1;
                    pend_d    = 1'b0;
                    state_d   = ST_ARM;
                end else if (div_ack) begin
                    rpm_d       = w_quot_sat;
                    rpm_valid_d = 1'b1;
                    stalled_d   = 1'b0;
                    if (w_accept || pend_q) begin
                        // Newest period wins: a same-cycle edge overrides
                        // whatever was waiting in the slot.
                        den_d   = w_den_sat;
                        pend_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_MEAS;
                    end
                end else if (w_accept) begin
                    slot_d = w_cand;
                    pend_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_ARM;
                stalled_d = 1'b1;
                pend_d    = 1'b0;
            end
        endcase

        req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARM;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            cnt_q       <= 32'd0;
            pend_q      <= 1'b0;
            slot_q      <= 32'd0;
            den_q       <= 32'd0;
            req_q       <= 1'b0;
            rpm_q       <= 10'd0;
            rpm_valid_q <= 1'b0;
            stalled_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            slot_q      <= slot_d;
            den_q       <= den_d;
            req_q       <= req_d;
            rpm_q       <= rpm_d;
            rpm_valid_q <= rpm_valid_d;
            stalled_q   <= stalled_d;
        end
    end

    assign div_req   = req_q;
    assign div_num   = C_DIV_NUM;
    assign div_den   = den_q;
    assign rpm       = rpm_q;
    assign rpm_valid = rpm_valid_q;
    assign stalled   = stalled_q;

endmodule
`default_nettype wire

// File: tb/tb_rpm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpm_scheduler
// Purpose  : Directed self-checking bench for rpm_scheduler. Runs the design
//            with a scaled clock rate and timeout so every scenario fits in a
//            short run: CLK_HZ=500000 (div_num=30000000), MIN_PERIOD=100,
//            TIMEOUT_CYCLES=5000, POLES*GEAR=80. A small divider model acks
//            in the 34th cycle of div_req.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rpm_scheduler;

    localparam int ACK_DELAY = 34;

    logic        clk50M;
    logic        rst_n;
    logic        blips;
    logic        div_req;
    logic [31:0] div_num;
    logic [31:0] div_den;
    logic        div_ack;
    logic [31:0] div_quot;
    logic [9:0]  rpm;
    logic        rpm_valid;
    logic        stalled;

    int n_checks = 0;
    int n_fail   = 0;

    // Divider model control and monitor state
    bit ack_en        = 1'b1;
    int late_ack_req  = 0;
    int late_ack_done = 0;
    int ack_cnt       = 0;
    int valid_cnt     = 0;
    int req_rise_cnt  = 0;
    bit req_prev      = 1'b0;
    int last_rpm      = 0;
    int prev_rpm      = 0;

    int base_valid;
    int base_req;

    rpm_scheduler #(
        .CLK_HZ         (500000),
        .POLES          (16),
        .GEAR           (5),
        .MIN_PERIOD     (100),
        .TIMEOUT_CYCLES (5000)
    ) u_dut (
        .clk50M    (clk50M),
        .rst_n     (rst_n),
        .blips     (blips),
        .div_req   (div_req),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_ack   (div_ack),
        .div_quot  (div_quot),
        .rpm       (rpm),
        .rpm_valid (rpm_valid),
        .stalled   (stalled)
    );

    initial clk50M = 1'b0;
    always #5 clk50M = ~clk50M;

    // Divider model: computes the true quotient, acks in the 34th cycle of
    // an active request, or emits one stray ack on demand.
    initial begin
        div_ack  = 1'b0;
        div_quot = 32'd0;
    end
    always @(posedge clk50M) begin
        #1;
        if (div_ack) begin
            div_ack = 1'b0;
            ack_cnt = 0;
        end else if (late_ack_req != late_ack_done) begin
            late_ack_done = late_ack_req;
            div_quot      = 32'd500;
            div_ack       = 1'b1;
        end else if (ack_en && div_req) begin
            ack_cnt = ack_cnt + 1;
            if (ack_cnt == ACK_DELAY) begin
                div_quot = div_num / div_den;
                div_ack  = 1'b1;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // Output monitor
    always @(posedge clk50M) begin
        #1;
        if (rpm_valid) begin
            valid_cnt = valid_cnt + 1;
            prev_rpm  = last_rpm;
            last_rpm  = int'(rpm);
        end
        if (div_req && !req_prev) req_rise_cnt = req_rise_cnt + 1;
        req_prev = div_req;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge followed by a full period of p cycles (half high).
    task automatic blip_period(input int p);
        blips = 1'b1;
        repeat (p / 2) @(negedge clk50M);
        blips = 1'b0;
        repeat (p - p / 2) @(negedge clk50M);
    endtask

    // 100-cycle period with a 2-cycle glitch 70 cycles after the real edge.
    task automatic blip_glitch();
        blips = 1'b1;
        repeat (50) @(negedge clk50M);
        blips = 1'b0;
        repeat (20) @(negedge clk50M);
        blips = 1'b1;
        repeat (2) @(negedge clk50M);
        blips = 1'b0;
        repeat (28) @(negedge clk50M);
    endtask

    initial begin
        rst_n = 1'b0;
        blips = 1'b0;
        repeat (4) @(negedge clk50M);

        // Reset values
        check_eq("rst_rpm",       32'(rpm),       32'd0);
        check_eq("rst_rpm_valid", 32'(rpm_valid), 32'd0);
        check_eq("rst_stalled",   32'(stalled),   32'd1);
        check_eq("rst_div_req",   32'(div_req),   32'd0);
        check_eq("rst_div_den",   div_den,        32'd0);
        check_eq("rst_div_num",   div_num,        32'd30000000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk50M);

        // Steady 375-cycle wave: den 30000, rpm 1000
        blip_period(375);
        check_eq("arm_first_edge_no_req", 32'(req_rise_cnt), 32'd0);
        check_eq("arm_first_edge_stalled", 32'(stalled), 32'd1);
        repeat (4) blip_period(375);
        check_eq("steady_valid_cnt", 32'(valid_cnt), 32'd4);
        check_eq("steady_req_cnt",   32'(req_rise_cnt), 32'd4);
        check_eq("steady_den",       div_den, 32'd30000);
        check_eq("steady_rpm",       32'(last_rpm), 32'd1000);
        check_eq("steady_stalled",   32'(stalled), 32'd0);
        check_eq("steady_req_idle",  32'(div_req), 32'd0);

        // Period 3000: den 240000, rpm 125
        repeat (3) blip_period(3000);
        check_eq("p3000_den",       div_den, 32'd240000);
        check_eq("p3000_rpm",       32'(last_rpm), 32'd125);
        check_eq("p3000_valid_cnt", 32'(valid_cnt), 32'd7);

        // Period 100 (= MIN_PERIOD): quot 3750 saturates to 1023; glitch rejected
        repeat (3) blip_period(100);
        check_eq("p100_rpm_sat", 32'(last_rpm), 32'd1023);
        base_req   = req_rise_cnt;
        base_valid = valid_cnt;
        blip_glitch();
        blip_period(100);
        check_eq("glitch_req_cnt",   32'(req_rise_cnt - base_req), 32'd2);
        check_eq("glitch_valid_cnt", 32'(valid_cnt - base_valid), 32'd2);
        check_eq("glitch_den",       div_den, 32'd8000);
        check_eq("glitch_rpm",       32'(last_rpm), 32'd1023);

        // Pending slot: edges measuring 400, 450, 500 with ack held off
        blip_period(400);
        ack_en = 1'b0;
        blip_period(450);
        blip_period(500);
        blips = 1'b1;
        repeat (10) @(negedge clk50M);
        check_eq("pend_req_held", 32'(div_req), 32'd1);
        check_eq("pend_den_first", div_den, 32'd32000);
        base_valid = valid_cnt;
        ack_en = 1'b1;
        repeat (100) @(negedge clk50M);
        check_eq("pend_valid_cnt", 32'(valid_cnt - base_valid), 32'd2);
        check_eq("pend_rpm_first", 32'(prev_rpm), 32'd937);
        check_eq("pend_rpm_newest", 32'(last_rpm), 32'd750);
        check_eq("pend_den_newest", div_den, 32'd40000);
        check_eq("pend_req_done", 32'(div_req), 32'd0);

        // Timeout during REQ
        ack_en = 1'b0;
        blips  = 1'b0;
        repeat (190) @(negedge clk50M);
        base_valid = valid_cnt;
        blips = 1'b1;
        repeat (4990) @(negedge clk50M);
        check_eq("tmo_before_req",     32'(div_req), 32'd1);
        check_eq("tmo_before_stalled", 32'(stalled), 32'd0);
        check_eq("tmo_den",            div_den, 32'd24000);
        repeat (20) @(negedge clk50M);
        check_eq("tmo_stalled",   32'(stalled), 32'd1);
        check_eq("tmo_rpm",       32'(rpm), 32'd0);
        check_eq("tmo_req_drop",  32'(div_req), 32'd0);
        check_eq("tmo_no_valid",  32'(valid_cnt - base_valid), 32'd0);
        late_ack_req = late_ack_req + 1;
        repeat (5) @(negedge clk50M);
        check_eq("late_ack_no_valid", 32'(valid_cnt - base_valid), 32'd0);
        check_eq("late_ack_rpm",      32'(rpm), 32'd0);
        check_eq("late_ack_stalled",  32'(stalled), 32'd1);
        check_eq("late_ack_req",      32'(div_req), 32'd0);

        // Restart after stall: first edge only re-arms
        ack_en = 1'b1;
        blips  = 1'b0;
        repeat (20) @(negedge clk50M);
        base_req = req_rise_cnt;
        blip_period(300);
        check_eq("restart_first_no_req", 32'(req_rise_cnt - base_req), 32'd0);
        check_eq("restart_first_stalled", 32'(stalled), 32'd1);
        blip_period(300);
        check_eq("restart_second_req", 32'(req_rise_cnt - base_req), 32'd1);
        check_eq("restart_rpm", 32'(last_rpm), 32'd1023);
        check_eq("restart_stalled", 32'(stalled), 32'd0);

        // Asynchronous reset in the middle of REQ
        ack_en = 1'b0;
        blips  = 1'b1;
        repeat (10) @(negedge clk50M);
        check_eq("midreq_req", 32'(div_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_rpm",       32'(rpm), 32'd0);
        check_eq("arst_rpm_valid", 32'(rpm_valid), 32'd0);
        check_eq("arst_stalled",   32'(stalled), 32'd1);
        check_eq("arst_div_req",   32'(div_req), 32'd0);
        check_eq("arst_div_den",   div_den, 32'd0);
        check_eq("arst_div_num",   div_num, 32'd30000000);
        blips = 1'b0;
        repeat (3) @(negedge clk50M);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        repeat (20) @(negedge clk50M);
        base_req = req_rise_cnt;
        blip_period(400);
        check_eq("post_rst_first_no_req", 32'(req_rise_cnt - base_req), 32'd0);
        blip_period(400);
        check_eq("post_rst_second_req", 32'(req_rise_cnt - base_req), 32'd1);
        check_eq("post_rst_rpm", 32'(last_rpm), 32'd937);
        check_eq("post_rst_den", div_den, 32'd32000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
